// File: rtl/seq_pattern_fsm.sv
// Run-time programmable serial pattern validator with held accept/reject verdicts.
// Define SEQ_FSM_TIMEOUT_EN to build in the inter-symbol timeout abort.
//
// state     | meaning
// ----------+-----------------------------------------------
// ST_IDLE   | no partial match, no verdict held (pos = 0)
// ST_MATCH  | partial match in progress (0 < pos < len)
// ST_ACCEPT | full pattern matched, accept held
// ST_REJECT | mismatch or timeout, reject held
module seq_pattern_fsm #(
  parameter int                          DATA_W       = 8,
  parameter int                          MAX_LEN      = 8,
  parameter int                          INIT_LEN     = 3,
  parameter logic [DATA_W*MAX_LEN-1:0]   INIT_PATTERN = 64'h0000_0000_0054_4143,
  parameter int                          TIMEOUT_CYC  = 1000,
  localparam int                         IDX_W        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1,
  localparam int                         LEN_W        = $clog2(MAX_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [DATA_W-1:0] cfg_char,
  input  logic              cfg_len_we,
  input  logic [LEN_W-1:0]  cfg_len,
  output logic              accept,
  output logic              reject,
  output logic              busy,
  output logic [LEN_W-1:0]  match_pos,
  output logic [15:0]       match_count,
  output logic              timeout
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_MATCH  = 2'd1;
  localparam logic [1:0] ST_ACCEPT = 2'd2;
  localparam logic [1:0] ST_REJECT = 2'd3;

  logic [1:0]        state;
  logic [LEN_W-1:0]  pos;
  logic [LEN_W-1:0]  len;
  logic [DATA_W-1:0] pattern [MAX_LEN];

  logic              cfg_any;
  logic [DATA_W-1:0] cmp_char;
  logic              hit;
  logic [LEN_W-1:0]  pos_nxt;
  logic              last;
  logic [LEN_W-1:0]  len_clamped;
  logic              tmr_fire;

  assign cfg_any     = cfg_we | cfg_len_we;
  assign cmp_char    = (state == ST_MATCH) ? pattern[pos[IDX_W-1:0]] : pattern[0];
  assign hit         = (len != '0) && (data_in == cmp_char);
  assign pos_nxt     = pos + 1'b1;
  assign last        = (pos_nxt == len);
  assign len_clamped = (cfg_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cfg_len;

  assign busy      = (state == ST_MATCH);
  assign match_pos = pos;

`ifdef SEQ_FSM_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

  // Down-counter reloaded by every symbol; terminal count ends the partial match.
  logic [TMR_W-1:0] tmr;

  assign tmr_fire = (state == ST_MATCH) && !data_valid && !cfg_any && (tmr <= TMR_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      tmr <= TMR_W'(TIMEOUT_CYC - 1);
    end else if (data_valid || cfg_any) begin
      tmr <= TMR_W'(TIMEOUT_CYC - 1);
    end else if ((state == ST_MATCH) && !tmr_fire) begin
      tmr <= tmr - 1'b1;
    end
  end
`else
  // TIMEOUT_CYC only matters when the timer is built in.
  logic unused_timeout_cyc;
  assign unused_timeout_cyc = |TIMEOUT_CYC;
  assign tmr_fire           = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      pos         <= '0;
      len         <= LEN_W'(INIT_LEN);
      accept      <= 1'b0;
      reject      <= 1'b0;
      match_count <= '0;
      timeout     <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++) begin
        pattern[i] <= INIT_PATTERN[i*DATA_W +: DATA_W];
      end
    end else begin
      timeout <= 1'b0;
      if (cfg_any) begin
        // Reconfiguration always aborts; a symbol arriving alongside is dropped.
        if (cfg_we && (int'(cfg_idx) < MAX_LEN)) begin
          pattern[cfg_idx] <= cfg_char;
        end
        if (cfg_len_we) begin
          len <= len_clamped;
        end
        state  <= ST_IDLE;
        pos    <= '0;
        accept <= 1'b0;
        reject <= 1'b0;
      end else if (data_valid) begin
        accept <= 1'b0;
        reject <= 1'b0;
        if (hit) begin
          if (last) begin
            state  <= ST_ACCEPT;
            accept <= 1'b1;
            pos    <= '0;
            if (match_count != 16'hFFFF) begin
              match_count <= match_count + 16'd1;
            end
          end else begin
            state <= ST_MATCH;
            pos   <= pos_nxt;
          end
        end else begin
          state  <= ST_REJECT;
          reject <= 1'b1;
          pos    <= '0;
        end
      end else if (tmr_fire) begin
        state   <= ST_REJECT;
        reject  <= 1'b1;
        accept  <= 1'b0;
        pos     <= '0;
        timeout <= 1'b1;
      end
    end
  end

endmodule
